// File: rtl/exc_ctrl_if.sv
// Exception-scheduler bundle: MEM-stage exception sources and fetch status in,
// CP0 event inputs and pipeline flush/redirect controls out.
interface exc_ctrl_if;
  logic        valid_m;
  logic        stall_m;
  logic [31:0] pc_m;
  logic [31:0] mem_addr_m;
  logic        is_in_delayslot_m;
  logic [7:0]  exc_flags_m;
  logic        eret_m;
  logic [31:0] status_i;
  logic [31:0] cause_i;
  logic [31:0] epc_i;
  logic        inst_req_pending;
  logic        inst_data_ok;

  logic [31:0] excepttype_o;
  logic [31:0] current_inst_addr_o;
  logic        is_in_delayslot_o;
  logic [31:0] bad_addr_o;
  logic        flush_o;
  logic        busy_o;
  logic        newpc_valid_o;
  logic [31:0] newpc_o;

  modport master (
    output valid_m, stall_m, pc_m, mem_addr_m, is_in_delayslot_m, exc_flags_m,
           eret_m, status_i, cause_i, epc_i, inst_req_pending, inst_data_ok,
    input  excepttype_o, current_inst_addr_o, is_in_delayslot_o, bad_addr_o,
           flush_o, busy_o, newpc_valid_o, newpc_o
  );

  modport slave (
    input  valid_m, stall_m, pc_m, mem_addr_m, is_in_delayslot_m, exc_flags_m,
           eret_m, status_i, cause_i, epc_i, inst_req_pending, inst_data_ok,
    output excepttype_o, current_inst_addr_o, is_in_delayslot_o, bad_addr_o,
           flush_o, busy_o, newpc_valid_o, newpc_o
  );
endinterface

// File: rtl/exc_ctrl.sv
// Picks one MEM-stage exception/interrupt by priority, commits it to CP0 at T+1 and
// redirects fetch at T+2 or later; the redirect waits out any in-flight fetch transaction.
module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
  parameter logic [31:0] NONE_CODE  = 32'hFFFFFFFF
) (
  input  logic      clk,
  input  logic      rst,
  exc_ctrl_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_COMMIT, S_WAIT_IF, S_REDIRECT} state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_int_q;
  logic [4:0]  r_code;
  logic [31:0] r_pc;
  logic        r_ds;
  logic [31:0] r_bad;
  logic [31:0] r_target;

  logic        w_int_req;
  logic        w_hit;
  logic        w_det;
  logic [4:0]  w_code;
  logic [31:0] w_bad;
  logic        w_unused;

  assign w_unused  = ^{bus.status_i[31:16], bus.status_i[7:2],
                       bus.cause_i[31:16], bus.cause_i[7:0]};
  assign w_int_req = (|(bus.cause_i[15:8] & bus.status_i[15:8]))
                     & bus.status_i[0] & ~bus.status_i[1];

  // Interrupt outranks every synchronous exception; bad address only for AdEL/AdES.
  always_comb begin
    w_hit  = 1'b1;
    w_code = 5'h00;
    w_bad  = 32'd0;
    if (r_int_q) begin
      w_code = 5'h00;
    end else if (bus.exc_flags_m[0]) begin
      w_code = 5'h04;
      w_bad  = bus.pc_m;
    end else if (bus.exc_flags_m[1]) begin
      w_code = 5'h0a;
    end else if (bus.exc_flags_m[2]) begin
      w_code = 5'h0c;
    end else if (bus.exc_flags_m[3]) begin
      w_code = 5'h0d;
    end else if (bus.exc_flags_m[4]) begin
      w_code = 5'h08;
    end else if (bus.exc_flags_m[5]) begin
      w_code = 5'h09;
    end else if (bus.exc_flags_m[6]) begin
      w_code = 5'h04;
      w_bad  = bus.mem_addr_m;
    end else if (bus.exc_flags_m[7]) begin
      w_code = 5'h05;
      w_bad  = bus.mem_addr_m;
    end else if (bus.eret_m) begin
      w_code = 5'h0e;
    end else begin
      w_hit  = 1'b0;
    end
  end

  assign w_det = (r_state == S_IDLE) & bus.valid_m & ~bus.stall_m & w_hit;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (w_det) w_next = S_COMMIT;
      S_COMMIT:   w_next = bus.inst_req_pending ? S_WAIT_IF : S_REDIRECT;
      S_WAIT_IF:  if (bus.inst_data_ok) w_next = S_REDIRECT;
      S_REDIRECT: w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_int_q  <= 1'b0;
      r_code   <= 5'd0;
      r_pc     <= 32'd0;
      r_ds     <= 1'b0;
      r_bad    <= 32'd0;
      r_target <= 32'd0;
    end else begin
      r_state <= w_next;
      r_int_q <= w_int_req;
      if (w_det) begin
        r_code   <= w_code;
        r_pc     <= bus.pc_m;
        r_ds     <= bus.is_in_delayslot_m;
        r_bad    <= w_bad;
        // eret only wins when nothing else is pending, so its code alone selects EPC.
        r_target <= (w_code == 5'h0e) ? bus.epc_i : EXC_VECTOR;
      end
    end
  end

  assign bus.excepttype_o        = (r_state == S_COMMIT) ? {27'd0, r_code} : NONE_CODE;
  assign bus.current_inst_addr_o = r_pc;
  assign bus.is_in_delayslot_o   = (r_state == S_COMMIT) & r_ds;
  assign bus.bad_addr_o          = r_bad;
  assign bus.flush_o             = (r_state != S_IDLE);
  assign bus.busy_o              = (r_state != S_IDLE);
  assign bus.newpc_valid_o       = (r_state == S_REDIRECT);
  assign bus.newpc_o             = r_target;

endmodule
